window_line_buffer: RTL and testbench

- Upstream neighbour of the NPU pixel path. Converts a raster-order 8-bit pixel stream into 3x3 pixel windows for the convolution datapath.
- Holds two previous image rows in line buffers plus a 3x3 shift window.
- Emits one window per interior pixel position, with the window's centre coordinates, so the downstream delay/alignment stage and the MAC array see aligned data.

---
 rtl/window_line_buffer.sv | 113 +++++++++++
 tb/tb_window_line_buffer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/window_line_buffer.sv
// Raster 8-bit pixel stream -> 3x3 windows with centre coordinates; 1 clock from accept to window.
// No backpressure: every in_valid pixel is accepted; idle cycles hold all state and outputs.
module window_line_buffer #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [7:0]                    input_pixel,
    output logic                          window_valid,
    output logic [71:0]                   window_pixels,
    output logic [$clog2(IMG_HEIGHT)-1:0] window_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  window_col,
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, cur_col, win_col_q, win_col_d;
    logic [RW-1:0] row_q, row_d, cur_row, win_row_q, win_row_d;
    logic [7:0]    lb0_mem [IMG_WIDTH];
    logic [7:0]    lb1_mem [IMG_WIDTH];
    logic [7:0]    lb0_rd, lb1_rd;
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic [71:0]   win_pix_q, win_pix_d;
    logic          win_vld_q, win_vld_d, frame_done_q, frame_done_d, emit;

    always_comb begin
        // A start-of-frame pixel is position (0,0) whatever the counters say.
        cur_col      = in_sof ? '0 : col_q;
        cur_row      = in_sof ? '0 : row_q;
        lb0_rd       = lb0_mem[cur_col];
        lb1_rd       = lb1_mem[cur_col];
        emit         = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_pix_d    = win_pix_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_vld_d    = emit;
        frame_done_d = emit && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]   = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = input_pixel;
        end
        // Output registers only move on a real window, so they hold the last one otherwise.
        if (emit) begin
            for (int k = 0; k < 9; k++) begin
                win_pix_d[8*k +: 8] = win_d[k];
            end
            win_row_d = cur_row - RW'(1);
            win_col_d = cur_col - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_pix_q    <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_pix_q    <= win_pix_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_vld_q    <= win_vld_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers are unreset storage; stale rows are never emitted thanks to the row/col gate.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1_mem[cur_col] <= lb0_rd;
            lb0_mem[cur_col] <= input_pixel;
        end
    end

    assign window_valid  = win_vld_q;
    assign window_pixels = win_pix_q;
    assign window_row    = win_row_q;
    assign window_col    = win_col_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer at 5x4: directed frames, gaps, resync, reset, back-to-back, random.
module tb_window_line_buffer;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sof;
    logic [7:0]  input_pixel;
    logic        window_valid, frame_done;
    logic [71:0] window_pixels;
    logic [1:0]  window_row;
    logic [2:0]  window_col;

    window_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .input_pixel(input_pixel), .window_valid(window_valid),
        .window_pixels(window_pixels), .window_row(window_row),
        .window_col(window_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          img [H][W];
    int          m_row, m_col;
    int          win_cnt, fd_cnt;
    logic [71:0] last_win;
    int          last_row, last_col;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0;
        last_win = '0; last_row = 0; last_col = 0;
    endtask

    // Drive one pixel, then check the window the model predicts for that position.
    task automatic send(input logic [7:0] pix, input logic sof);
        int r, c;
        logic exp_v, exp_fd;
        logic [71:0] ew;
        in_valid = 1'b1; in_sof = sof; input_pixel = pix;
        r = sof ? 0 : m_row;
        c = sof ? 0 : m_col;
        img[r][c] = pix;
        m_col = c + 1; m_row = r;
        if (m_col == W) begin
            m_col = 0;
            m_row = (r == H - 1) ? 0 : r + 1;
        end
        exp_v  = (r >= 2) && (c >= 2);
        exp_fd = exp_v && (r == H - 1) && (c == W - 1);
        ew = '0;
        if (exp_v) begin
            for (int k = 0; k < 9; k++) ew[8*k +: 8] = 8'(img[r - 2 + k / 3][c - 2 + k % 3]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0;
        chk("window_valid", 72'(window_valid), 72'(exp_v));
        chk("frame_done", 72'(frame_done), 72'(exp_fd));
        if (exp_v) begin
            win_cnt++;
            if (exp_fd) fd_cnt++;
            last_win = ew; last_row = r - 1; last_col = c - 1;
            chk("window_pixels", window_pixels, ew);
            chk("window_row", 72'(window_row), 72'(last_row));
            chk("window_col", 72'(window_col), 72'(last_col));
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_sof = 1'b0; input_pixel = 8'($urandom);
        @(posedge clk);
        #1;
        chk("idle_valid", 72'(window_valid), 72'd0);
        chk("idle_frame_done", 72'(frame_done), 72'd0);
        chk("idle_hold_pixels", window_pixels, last_win);
        chk("idle_hold_row", 72'(window_row), 72'(last_row));
        chk("idle_hold_col", 72'(window_col), 72'(last_col));
    endtask

    // mode 0: continuous, 1: gap every other cycle, 2: random pixels and random gaps
    task automatic run_frame(input int base, input int mode);
        logic [7:0] pix;
        win_cnt = 0;
        for (int i = 0; i < W * H; i++) begin
            pix = (mode == 2) ? 8'($urandom) : 8'(base + i);
            send(pix, i == 0);
            if (mode != 2 && i == 12)
                chk("first_window", window_pixels,
                    base == 0 ? 72'h0c0b0a070605020100 : 72'h706f6e6b6a69666564);
            if (mode != 2 && base == 0 && i == W * H - 1) begin
                chk("last_window", window_pixels, 72'h1312110e0d0c090807);
                chk("last_row", 72'(window_row), 72'd2);
                chk("last_col", 72'(window_col), 72'd3);
                chk("last_frame_done", 72'(frame_done), 72'd1);
            end
            if (mode == 1 && i < W * H - 1) idle();
            if (mode == 2) repeat ($urandom_range(0, 2)) idle();
        end
        chk("windows_per_frame", 72'(win_cnt), 72'd6);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; input_pixel = '0;
        model_reset();
        #12;
        chk("reset_valid", 72'(window_valid), 72'd0);
        chk("reset_frame_done", 72'(frame_done), 72'd0);
        chk("reset_pixels", window_pixels, 72'd0);
        chk("reset_row", 72'(window_row), 72'd0);
        chk("reset_col", 72'(window_col), 72'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // full frame, then the same frame with alternate-cycle gaps
        fd_cnt = 0;
        run_frame(0, 0);
        chk("frame_done_count", 72'(fd_cnt), 72'd1);
        idle();
        run_frame(0, 1);

        // resync: partial frame then a fresh start-of-frame
        win_cnt = 0;
        for (int i = 0; i < 7; i++) send(8'(200 + i), i == 0);
        chk("no_window_partial", 72'(win_cnt), 72'd0);
        run_frame(0, 0);

        // asynchronous reset right after pixel 13 is accepted
        for (int i = 0; i < 14; i++) send(8'(50 + i), i == 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 72'(window_valid), 72'd0);
        chk("async_rst_pixels", window_pixels, 72'd0);
        chk("async_rst_row", 72'(window_row), 72'd0);
        chk("async_rst_col", 72'(window_col), 72'd0);
        chk("async_rst_frame_done", 72'(frame_done), 72'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        idle();
        run_frame(0, 0);

        // back-to-back frames with no idle cycle between them
        fd_cnt = 0;
        run_frame(0, 0);
        run_frame(100, 0);
        chk("frame_done_twice", 72'(fd_cnt), 72'd2);

        // random pixels with random gaps
        for (int f = 0; f < 4; f++) run_frame(0, 2);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
